instr_encoder: RTL and testbench



---
 rtl/instr_encoder.sv | 169 ++++++++++++++++
 tb/tb_instr_encoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// enc_fifo: small synchronous FIFO with a registered occupancy counter and a synchronous clear.
// Latency: a pushed word is visible at the head one clock after the write edge (no bypass).
// Backpressure: full depends only on occupancy; a pop never combinationally frees a slot.
module enc_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          do_push;
  logic          do_pop;

  assign full    = (occ == (AW+1)'(DEPTH));
  assign rd_vld  = (occ != '0);
  assign do_push = wr_vld && !full && !flush;
  assign do_pop  = rd_vld && rd_rdy && !flush;
  // Head is forced to zero when empty so the output is clean out of reset and after flush.
  assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end
endmodule

// instr_encoder: assembles MIPS instruction words from descriptors and queues them for the imem writer.
// Latency: word appears on out_instr one clock after the accepting edge when the queue was empty.
// Backpressure: in_ready is low when the queue is full or during flush; no path from out_ready.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_kind,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [5:0]       in_funct,
  input  logic [15:0]      in_imm,
  input  logic [25:0]      in_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             err
);
  localparam logic [3:0] K_RTYPE = 4'd0;
  localparam logic [3:0] K_ANDI  = 4'd1;
  localparam logic [3:0] K_XORI  = 4'd2;
  localparam logic [3:0] K_LUI   = 4'd3;
  localparam logic [3:0] K_ORI   = 4'd4;
  localparam logic [3:0] K_LW    = 4'd5;
  localparam logic [3:0] K_SW    = 4'd6;
  localparam logic [3:0] K_BEQ   = 4'd7;
  localparam logic [3:0] K_ADDI  = 4'd8;
  localparam logic [3:0] K_J     = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [31:0] enc_word;
  logic        kind_legal;
  logic        fifo_full;
  logic        accept;
  logic        push_vld;

  assign in_ready = !flush && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign push_vld = accept && kind_legal;

  // Field packing per instruction format; kinds 10-15 encode nothing and are flagged illegal.
  always_comb begin
    enc_word   = '0;
    kind_legal = 1'b1;
    case (in_kind)
      K_RTYPE: enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, in_shamt, in_funct};
      K_ANDI:  enc_word = {OP_ANDI, in_rs, in_rt, in_imm};
      K_XORI:  enc_word = {OP_XORI, in_rs, in_rt, in_imm};
      K_LUI:   enc_word = {OP_LUI, 5'd0, in_rt, in_imm};
      K_ORI:   enc_word = {OP_ORI, in_rs, in_rt, in_imm};
      K_LW:    enc_word = {OP_LW, in_rs, in_rt, in_imm};
      K_SW:    enc_word = {OP_SW, in_rs, in_rt, in_imm};
      K_BEQ:   enc_word = {OP_BEQ, in_rs, in_rt, in_imm};
      K_ADDI:  enc_word = {OP_ADDI, in_rs, in_rt, in_imm};
      K_J:     enc_word = {OP_J, in_target};
      default: kind_legal = 1'b0;
    endcase
  end

  enc_fifo #(
    .W     (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .wr_vld (push_vld),
    .wr_dat (enc_word),
    .rd_rdy (out_ready),
    .rd_vld (out_valid),
    .rd_dat (out_instr),
    .full   (fifo_full)
  );

  // Accepted-descriptor statistics; survive flush, wrap naturally, err is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt    <= '0;
      illegal_cnt <= '0;
      err         <= 1'b0;
    end else if (accept) begin
      if (kind_legal) begin
        word_cnt <= word_cnt + 1'b1;
      end else begin
        illegal_cnt <= illegal_cnt + 1'b1;
        err         <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed plus randomized checks of instr_encoder against a queue-based model.
// Latency: model expects a pushed word at the head one clock after acceptance.
// Backpressure: model derives in_ready from its own queue size and flush.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  // Opcode per kind 0..9, as plain numbers.
  localparam int OPC [10] = '{0, 12, 14, 15, 13, 35, 43, 4, 8, 2};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_kind = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_instr;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] illegal_cnt;
  logic             err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mq [$];
  int m_words = 0;
  int m_ill = 0;
  bit m_err = 1'b0;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .word_cnt(word_cnt),
    .illegal_cnt(illegal_cnt), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(int kind, int rs, int rt, int rd, int sh,
                                           int fn, int imm, int tgt);
    longint w;
    if (kind == 0)
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048
        + longint'(sh) * 64 + longint'(fn);
    else if (kind == 9)
      w = longint'(OPC[9]) * 67108864 + longint'(tgt);
    else if (kind == 3)
      w = longint'(OPC[3]) * 67108864 + longint'(rt) * 65536 + longint'(imm);
    else
      w = longint'(OPC[kind]) * 67108864 + longint'(rs) * 2097152
        + longint'(rt) * 65536 + longint'(imm);
    return w[31:0];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(int kind, int rs, int rt, int rd, int sh, int fn, int imm, int tgt);
    in_valid  = 1'b1;
    in_kind   = 4'(kind);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_shamt  = 5'(sh);
    in_funct  = 6'(fn);
    in_imm    = 16'(imm);
    in_target = 26'(tgt);
  endtask

  task automatic drive_rand(bit legal_only);
    int k;
    k = legal_only ? $urandom_range(9, 0) : $urandom_range(15, 0);
    drive(k, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  // One clock: check all outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit exp_rdy;
    bit acc;
    bit pop;
    @(negedge clk);
    exp_rdy = !flush && (mq.size() < DEPTH);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
    chk("out_instr", out_instr, (mq.size() != 0) ? mq[0] : 32'd0);
    chk("word_cnt", 32'(word_cnt), 32'(m_words & 'hFFFF));
    chk("illegal_cnt", 32'(illegal_cnt), 32'(m_ill & 'hFFFF));
    chk("err", {31'd0, err}, {31'd0, m_err});
    acc = in_valid && exp_rdy;
    pop = (mq.size() != 0) && out_ready;
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc && in_kind < 10)
        mq.push_back(ref_word(in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target));
    end
    if (acc) begin
      if (in_kind < 10) m_words++;
      else begin
        m_ill++;
        m_err = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    // Reset values.
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADDI rs=1 rt=2 imm=5.
    drive(8, 1, 2, 0, 0, 0, 5, 0);
    step();
    in_valid = 1'b0;
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_word", out_instr, 32'h20220005);
    chk("addi_cnt", 32'(word_cnt), 32'd1);
    out_ready = 1'b1;
    step();

    // LW, J, RTYPE streamed with out_ready=1.
    drive(5, 29, 8, 0, 0, 0, 'h0004, 0);
    step();
    chk("lw_word", out_instr, 32'h8FA80004);
    drive(9, 0, 0, 0, 0, 0, 0, 'h0000100);
    step();
    chk("j_word", out_instr, 32'h08000100);
    drive(0, 1, 2, 3, 0, 'h20, 0, 0);
    step();
    chk("rtype_word", out_instr, 32'h00221820);
    in_valid = 1'b0;
    step();

    // LUI ignores rs.
    out_ready = 1'b0;
    drive(3, 7, 4, 0, 0, 0, 'h1234, 0);
    step();
    in_valid = 1'b0;
    chk("lui_word", out_instr, 32'h3C041234);
    out_ready = 1'b1;
    step();

    // Fill to DEPTH with the consumer stalled, offer a fifth, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_rand(1'b1);
      step();
    end
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    drive_rand(1'b1);
    step();
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < DEPTH; i++) step();

    // Illegal kind: no word, counters and sticky err.
    drive(12, 1, 2, 3, 4, 5, 6, 7);
    step();
    in_valid = 1'b0;
    chk("ill_no_word", {31'd0, out_valid}, 32'd0);
    chk("ill_cnt", 32'(illegal_cnt), 32'd1);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_word_cnt", 32'(word_cnt), 32'(m_words));
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Flush with three buffered words and a descriptor offered.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      step();
    end
    flush = 1'b1;
    drive_rand(1'b1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_word_cnt", 32'(word_cnt), 32'(m_words));
    step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3, 0) != 0) drive_rand(1'b0);
      else in_valid = 1'b0;
      out_ready = ($urandom_range(2, 0) != 0);
      flush = ($urandom_range(19, 0) == 0);
      step();
    end
    flush = 1'b0;

    // Asynchronous reset with words buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_rand(1'b1);
      step();
    end
    in_valid = 1'b0;
    chk("pre_arst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_instr", out_instr, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_word_cnt", 32'(word_cnt), 32'd0);
    mq.delete();
    m_words = 0;
    m_ill = 0;
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_rand(1'b1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
